// File: rtl/axi_lite_memory.sv
// rtl/axi_lite_memory.sv - AXI4-Lite subordinate serving word-addressed RAM
// Independent read and write FSMs, one outstanding transaction per direction.
module axi_lite_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddress,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddress,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);

  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic running;

  logic        aw_full, w_full;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;

  logic        ar_hs, aw_hs, w_hs, commit;
  logic [31:0] addr_eff, data_eff;
  logic [3:0]  strb_eff;
  logic [1:0]  rd_resp, wr_resp;

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // DECERR outranks SLVERR: out-of-range is checked first.
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (a >= 32'(DEPTH_WORDS) * 32'd4) return 2'b11;
    if (a[1:0] != 2'b00) return 2'b10;
    return 2'b00;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) running <= 1'b0;
    else        running <= 1'b1;
  end

  assign arready = running && (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);
  assign ar_hs   = arvalid && arready;
  assign rd_resp = resp_of(araddress);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_next = R_RESP;
      R_RESP: if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= 32'h0;
      rresp <= 2'b00;
    end else if (ar_hs) begin
      rresp <= rd_resp;
      rdata <= (rd_resp == 2'b00) ? mem[araddress[ADDR_BITS+1:2]] : 32'h0;
    end
  end

  assign awready = running && (w_state == W_IDLE) && !aw_full;
  assign wready  = running && (w_state == W_IDLE) && !w_full;
  assign bvalid  = (w_state == W_RESP);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // A held capture and a same-cycle handshake are interchangeable sources.
  assign addr_eff = aw_full ? aw_addr_q : awaddress;
  assign data_eff = w_full  ? w_data_q  : wdata;
  assign strb_eff = w_full  ? w_strb_q  : wstrb;
  assign commit   = (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_resp  = resp_of(addr_eff);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (commit) w_next = W_RESP;
      W_RESP: if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= 32'h0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bresp     <= 2'b00;
    end else if (commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bresp   <= wr_resp;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= awaddress;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && (wr_resp == 2'b00)) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_eff[i]) mem[addr_eff[ADDR_BITS+1:2]][8*i +: 8] <= data_eff[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_memory.sv
// tb/tb_axi_lite_memory.sv - directed and random checks of axi_lite_memory
// Reference model: a plain word array updated from the byte-strobe rules.
module tb_axi_lite_memory;

  logic        clk, reset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddress, wdata, araddress, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [256];

  axi_lite_memory dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (a >= 32'h400) return 2'b11;
    if (a % 4 != 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int cyc = 0;
    logic [1:0] er;
    awaddress = addr; wdata = data; wstrb = strb; awprot = 3'($urandom); bready = 1'b1;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done = 1;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("write_handshakes", 32'({aw_done, w_done}), 32'h3);
    er = exp_resp(addr);
    check("bvalid_latency", 32'(bvalid), 32'h1);
    check("bresp", 32'(bresp), 32'(er));
    @(posedge clk); #1;
    check("single_b", 32'(bvalid), 32'h0);
    check("awready_back", 32'(awready), 32'h1);
    bready = 1'b0;
    if (er == 2'b00)
      for (int i = 0; i < 4; i++)
        if (strb[i]) model[addr[9:2]][8*i +: 8] = data[8*i +: 8];
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold, output logic [31:0] got);
    bit done = 0, hs;
    int cyc = 0;
    logic [1:0] er;
    logic [31:0] ed;
    araddress = addr; arprot = 3'($urandom); rready = (hold == 0);
    while (!done && cyc < 50) begin
      arvalid = 1'b1;
      hs = arready;
      @(posedge clk); #1;
      if (hs) done = 1;
      cyc++;
    end
    arvalid = 1'b0;
    check("ar_handshake", 32'(done), 32'h1);
    er = exp_resp(addr);
    ed = (er == 2'b00) ? model[addr[9:2]] : 32'h0;
    check("rvalid_latency", 32'(rvalid), 32'h1);
    check("rresp", 32'(rresp), 32'(er));
    check("rdata", rdata, ed);
    got = rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("rvalid_held", 32'(rvalid), 32'h1);
      check("rdata_held", rdata, ed);
      check("arready_low", 32'(arready), 32'h0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    check("single_r", 32'(rvalid), 32'h0);
    check("arready_back", 32'(arready), 32'h1);
    rready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check("rst_bvalid", 32'(bvalid), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_readies", 32'({arready, awready, wready}), 32'h0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("readies_wait_run", 32'({arready, awready, wready}), 32'h0);
    @(posedge clk); #1;
    check("readies_up", 32'({arready, awready, wready}), 32'h7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_spurious", 32'({bvalid, rvalid}), 32'h0);
    end
  endtask

  initial begin
    logic [31:0] rd, a, old;
    int sel;
    reset = 1'b0;
    {awvalid, wvalid, bready, arvalid, rready} = '0;
    awaddress = '0; wdata = '0; wstrb = '0; araddress = '0; awprot = '0; arprot = '0;

    #12;
    check("reset_readies", 32'({arready, awready, wready}), 32'h0);
    check("reset_valids", 32'({rvalid, bvalid}), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_resps", 32'({rresp, bresp}), 32'h0);
    #11;
    reset = 1'b1;
    #1;
    check("first_readies_low", 32'({arready, awready, wready}), 32'h0);
    @(posedge clk); #1;
    check("first_readies_high", 32'({arready, awready, wready}), 32'h7);

    for (int i = 0; i < 256; i++) axi_write(32'(i * 4), $urandom, 4'hF, 0, 0);

    axi_write(32'h0, 32'h0000_0073, 4'hF, 0, 0);
    axi_read(32'h0, 0, rd);
    check("plan_fetch", rd, 32'h0000_0073);

    axi_write(32'h10, 32'h1122_3344, 4'hF, 0, 0);
    axi_write(32'h10, 32'hDEAD_BEEF, 4'b0011, 2, 0);
    axi_read(32'h10, 0, rd);
    check("plan_strb_merge", rd, 32'h1122_BEEF);
    axi_write(32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 1);
    axi_read(32'h10, 1, rd);
    check("plan_strb_zero", rd, 32'h1122_BEEF);

    axi_read(32'h400, 0, rd);
    axi_write(32'h402, 32'hCAFE_F00D, 4'hF, 1, 0);
    axi_read(32'h0, 0, rd);
    check("plan_decerr_nowrite", rd, 32'h0000_0073);
    axi_read(32'h6, 0, rd);
    axi_write(32'h6, 32'hCAFE_F00D, 4'hF, 0, 0);
    axi_read(32'h4, 0, rd);

    axi_read(32'h8, 5, rd);

    check("pre_concurrent_ready", 32'({arready, awready, wready}), 32'h7);
    old = model[8];
    awaddress = 32'h20; wdata = 32'hA5A5_0F0F; wstrb = 4'hF; araddress = 32'h20;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("conc_bvalid", 32'(bvalid), 32'h1);
    check("conc_rvalid", 32'(rvalid), 32'h1);
    check("conc_old_data", rdata, old);
    model[8] = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    check("conc_done", 32'({bvalid, rvalid}), 32'h0);
    bready = 1'b0; rready = 1'b0;
    axi_read(32'h20, 0, rd);
    check("conc_new_data", rd, 32'hA5A5_0F0F);

    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = 32'($urandom_range(0, 255) * 4);
      else if (sel == 7) a = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
      else               a = 32'h400 + 32'($urandom_range(0, 4000));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      else
        axi_read(a, int'($urandom_range(0, 3)), rd);
    end

    awaddress = 32'h30; wdata = 32'h1357_9BDF; wstrb = 4'hF; araddress = 32'h34;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("pend_both", 32'({bvalid, rvalid}), 32'h3);
    model[12] = 32'h1357_9BDF;
    pulse_reset();
    axi_read(32'h30, 0, rd);

    awaddress = 32'h40; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("partial_aw_held", 32'({awready, bvalid}), 32'h0);
    pulse_reset();
    axi_write(32'h44, 32'h2468_ACE0, 4'hF, 0, 0);
    axi_read(32'h40, 0, rd);
    axi_read(32'h44, 0, rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_memory.md
# axi_lite_memory

Synthesizable AXI4-Lite responder that serves word-addressed RAM to the `riscv` core's memory port, covering both instruction fetch and data load/store traffic. It is the subordinate end of the core's AW/W/B/AR/R interface and replaces behavioural memory models in simulation and on FPGA. Read and write channels run independently, one outstanding transaction per direction, with full valid/ready backpressure.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; decoded byte range is 0 .. DEPTH_WORDS*4-1.
- `ADDR_BITS`, $clog2(DEPTH_WORDS): word-index width.
- `clk` in 1: sole clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; 0 holds block in reset.
- `awvalid` in 1 / `awready` out 1 / `awaddress` in 32 / `awprot` in 3: write address channel (`awprot` accepted, ignored).
- `wvalid` in 1 / `wready` out 1 / `wdata` in 32 / `wstrb` in 4: write data channel, `wstrb[i]` enables byte i.
- `bvalid` out 1 / `bready` in 1 / `bresp` out 2: write response.
- `arvalid` in 1 / `arready` out 1 / `araddress` in 32 / `arprot` in 3: read address (`arprot` ignored).
- `rvalid` out 1 / `rready` in 1 / `rdata` out 32 / `rresp` out 2: read response.

## Operation
- Response codes: 2'b00 OKAY; 2'b10 SLVERR when `addr[1:0] != 0`; 2'b11 DECERR when `addr >= DEPTH_WORDS*4` (DECERR takes priority over SLVERR).
- Read FSM: R_IDLE -> R_RESP on `arvalid && arready`; R_RESP -> R_IDLE on `rvalid && rready`. `arready` = state is R_IDLE; `rvalid` = state is R_RESP.
- On AR handshake: latch `rresp`; if OKAY latch `rdata <= mem[addr[ADDR_BITS+1:2]]`, else `rdata <= 0`. `rdata`/`rresp` stable while `rvalid` high.
- Write FSM: W_IDLE (collect) -> W_RESP -> W_IDLE. AW and W captured independently into holding registers with flags `aw_full`, `w_full`; arrival in either order or same cycle.
- `awready` = W_IDLE && !aw_full; `wready` = W_IDLE && !w_full.
- Commit on the edge where both address and data are available (held or handshaking that cycle): if OKAY, write bytes of `mem[index]` where `wstrb[i]` set; error -> no write. Latch `bresp`, enter W_RESP, clear flags.
- W_RESP: `bvalid` = 1, both write readies 0; leave on `bvalid && bready`.
- `wstrb == 0` with OKAY address: no bytes modified, response OKAY.
- Memory array has no reset; contents undefined until written (simulation may preload via `$readmemh`).

## Timing
- During reset: `arready`, `awready`, `wready`, `rvalid`, `bvalid` = 0; `rdata` = 0; `rresp`, `bresp` = 2'b00; both FSMs in IDLE, flags clear.
- Readies are qualified by a registered `running` flag set on the first rising edge after `reset` goes high; readies are first 1 in the cycle after that edge.
- Read latency: AR handshake at edge N -> `rvalid` high after edge N, data valid same cycle. Earliest next AR handshake at edge N+2 with `rready` held high.
- Write latency: last of AW/W handshakes at edge N -> `bvalid` high after edge N. Earliest next AW/W handshake at edge N+2 with `bready` held high.
- Read and write to the same word committing at the same edge: read returns pre-write data.
- `reset` asserted mid-transaction: outstanding response dropped immediately (async), partial AW/W captures discarded, uncommitted write not performed.
- Valid never depends on ready; no combinational path from any input to any output.

## Test plan
- Preload mem[0]=0x00000073; AR 0x0 with `rready`=1 -> `rvalid` one cycle after handshake, `rdata`=0x00000073, `rresp`=00.
- W (0xDEADBEEF, strb 4'b0011) two cycles before AW 0x10 -> one B with `bresp`=00; read 0x10 over prior 0x11223344 -> 0x1122BEEF.
- AR 0x400 -> `rresp`=11, `rdata`=0; AW 0x402 + W -> `bresp`=11 (DECERR priority), memory unchanged; AR 0x6 -> `rresp`=10.
- Hold `rready`=0 for 5 cycles after AR 0x8 -> `rvalid`, `rdata` stable, `arready`=0 throughout; single transfer on release.
- Back-to-back: AW+W same cycle to 0x20 with `bready`=1, concurrent AR 0x20 same commit edge -> read returns old word, next read returns new word.
- Drop `reset` while `bvalid`=1 and `rvalid`=1 -> both 0 asynchronously; after release, readies return, no spurious B/R.
